// File: rtl/sb_cfg_pkg.sv
// Shared constants for the switch-box configuration loader: side codes, word fields,
// FSM encoding and default geometry.
package sb_cfg_pkg;

  localparam int unsigned NTB_DEF = 5;
  localparam int unsigned NLR_DEF = 4;
  localparam int unsigned W_DEF   = 6;

  localparam int unsigned SEL_LSB = 0;
  localparam int unsigned SEL_MSB = 2;
  localparam int unsigned SRC_LSB = 3;
  localparam int unsigned SRC_MSB = 5;

  localparam logic [2:0] SEL_NONE   = 3'd0;
  localparam logic [2:0] SEL_TOP    = 3'd1;
  localparam logic [2:0] SEL_RIGHT  = 3'd2;
  localparam logic [2:0] SEL_BOTTOM = 3'd3;
  localparam logic [2:0] SEL_LEFT   = 3'd4;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

endpackage

// File: rtl/sb_cfg_entry_check.sv
// Combinational legality check of one routing word, given its frame index
// (which fixes the side and wire position of the wire it configures).
module sb_cfg_entry_check
  import sb_cfg_pkg::*;
#(
  parameter int unsigned NTB = NTB_DEF,
  parameter int unsigned NLR = NLR_DEF,
  parameter int unsigned W   = W_DEF
) (
  input  logic [4:0]   idx_i,
  input  logic [W-1:0] word_i,
  output logic         legal_o
);

  localparam logic [4:0] TopEnd  = 5'(NTB);
  localparam logic [4:0] BotEnd  = 5'(2 * NTB);
  localparam logic [4:0] LeftEnd = 5'(2 * NTB + NLR);
  localparam logic [3:0] NtbLim  = 4'(NTB);
  localparam logic [3:0] NlrLim  = 4'(NLR);

  logic [2:0] sel;
  logic [2:0] src;
  logic [2:0] side;
  logic [4:0] pos;

  assign sel = word_i[SEL_MSB:SEL_LSB];
  assign src = word_i[SRC_MSB:SRC_LSB];

  always_comb begin
    if (idx_i < TopEnd) begin
      side = SEL_TOP;
      pos  = idx_i;
    end else if (idx_i < BotEnd) begin
      side = SEL_BOTTOM;
      pos  = idx_i - TopEnd;
    end else if (idx_i < LeftEnd) begin
      side = SEL_LEFT;
      pos  = idx_i - BotEnd;
    end else begin
      side = SEL_RIGHT;
      pos  = idx_i - LeftEnd;
    end
  end

  always_comb begin
    legal_o = 1'b1;
    case (sel)
      SEL_NONE:              legal_o = 1'b1;
      SEL_TOP, SEL_BOTTOM:   legal_o = ({1'b0, src} < NtbLim);
      SEL_RIGHT, SEL_LEFT:   legal_o = ({1'b0, src} < NlrLim);
      default:               legal_o = 1'b0;
    endcase
    // A wire may not be driven from itself.
    if (sel != SEL_NONE && sel == side && {2'b00, src} == pos) legal_o = 1'b0;
  end

endmodule

// File: rtl/sb_config_loader.sv
// Loads a frame of routing words into a shadow bank, checks each entry, and commits the
// whole bank atomically to the active switch-box configuration.
module sb_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int unsigned NTB = NTB_DEF,
  parameter int unsigned NLR = NLR_DEF,
  parameter int unsigned W   = W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic                             cfg_abort,
  input  logic [W-1:0]                     cfg_data,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [4:0]                       err_idx,
  output logic                             cfg_update,
  output logic [(2*NTB+2*NLR)*W-1:0]       cfg_active
);

  localparam int unsigned NENT = 2 * NTB + 2 * NLR;
  localparam logic [4:0]  Last = 5'(NENT - 1);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q;
  logic [W-1:0]     shadow_q [NENT];
  logic [NENT*W-1:0] shadow_flat;
  logic [NENT*W-1:0] active_q;
  logic             err_q, done_q, upd_q, busy_q;
  logic [4:0]       err_idx_q;
  logic             legal, accept, reject, commit;

  sb_cfg_entry_check #(
    .NTB (NTB),
    .NLR (NLR),
    .W   (W)
  ) u_check (
    .idx_i   (cnt_q),
    .word_i  (shadow_q[cnt_q]),
    .legal_o (legal)
  );

  always_comb begin
    for (int k = 0; k < int'(NENT); k++) shadow_flat[k*W +: W] = shadow_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cfg_start) state_d = StLoad;
      StLoad: begin
        if (cfg_abort)                    state_d = StIdle;
        else if (accept && cnt_q == Last) state_d = StCheck;
      end
      StCheck: begin
        if (cfg_abort || !legal) state_d = StIdle;
        else if (cnt_q == Last)  state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_ready  = (state_q == StLoad);
    accept     = cfg_ready && cfg_valid && !cfg_abort;
    reject     = (state_q == StCheck) && !cfg_abort && !legal;
    commit     = (state_q == StCommit);
    busy       = busy_q;
    done       = done_q;
    err        = err_q;
    err_idx    = err_idx_q;
    cfg_update = upd_q;
    cfg_active = active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      done_q    <= 1'b0;
      upd_q     <= 1'b0;
      busy_q    <= 1'b0;
      active_q  <= '0;
      for (int k = 0; k < int'(NENT); k++) shadow_q[k] <= '0;
    end else begin
      done_q <= reject || commit;
      upd_q  <= commit;
      busy_q <= (state_d != StIdle);
      if (state_q == StIdle && cfg_start) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (accept) begin
        shadow_q[cnt_q] <= cfg_data;
        cnt_q           <= (cnt_q == Last) ? '0 : cnt_q + 5'd1;
      end
      if (state_q == StCheck && !cfg_abort) cnt_q <= cnt_q + 5'd1;
      if (reject) begin
        err_q     <= 1'b1;
        err_idx_q <= cnt_q;
      end
      if (commit) active_q <= shadow_flat;
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// Randomized self-checking bench for sb_config_loader against a frame-level reference model.
module tb_sb_config_loader;

  localparam int NTB  = 5;
  localparam int NLR  = 4;
  localparam int W    = 6;
  localparam int NENT = 2 * NTB + 2 * NLR;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic                cfg_abort = 1'b0;
  logic [W-1:0]        cfg_data = '0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready, busy, done, err, cfg_update;
  logic [4:0]          err_idx;
  logic [NENT*W-1:0]   cfg_active;

  sb_config_loader #(
    .NTB (NTB),
    .NLR (NLR),
    .W   (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_idx    (err_idx),
    .cfg_update (cfg_update),
    .cfg_active (cfg_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0]      frame [NENT];
  logic [NENT*W-1:0] exp_active = '0;
  int e_edge, done_edge, extra;
  bit upd_at_done;

  // Reference legality rule, written directly from the side/position definition.
  function automatic bit legal_ref(int k, logic [5:0] w);
    int sel = int'(w[2:0]);
    int src = int'(w[5:3]);
    int side, pos;
    if (k < NTB)                begin side = 1; pos = k;                end
    else if (k < 2*NTB)         begin side = 3; pos = k - NTB;          end
    else if (k < 2*NTB + NLR)   begin side = 4; pos = k - 2*NTB;        end
    else                        begin side = 2; pos = k - 2*NTB - NLR;  end
    if (sel == 0) return 1'b1;
    if (sel > 4) return 1'b0;
    if ((sel == 1 || sel == 3) && src >= NTB) return 1'b0;
    if ((sel == 2 || sel == 4) && src >= NLR) return 1'b0;
    return !(sel == side && src == pos);
  endfunction

  function automatic int first_bad();
    for (int k = 0; k < NENT; k++) if (!legal_ref(k, frame[k])) return k;
    return -1;
  endfunction

  function automatic logic [NENT*W-1:0] pack_frame();
    logic [NENT*W-1:0] v;
    for (int k = 0; k < NENT; k++) v[k*W +: W] = frame[k];
    return v;
  endfunction

  function automatic logic [5:0] gen_word(bit allow_bad);
    logic [2:0] sel = 3'($urandom_range(0, 4));
    logic [2:0] src;
    if (sel == 1 || sel == 3) src = 3'($urandom_range(0, NTB - 1));
    else                      src = 3'($urandom_range(0, NLR - 1));
    if (allow_bad && $urandom_range(0, 9) == 0) return 6'($urandom);
    return {src, sel};
  endfunction

  task automatic start_frame();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  // Streams frame[] with optional random valid gaps; e_edge = edge of the last accept.
  task automatic stream(input bit gaps, input bit hold);
    int i = 0;
    int guard = 0;
    bit rdy;
    while (i < NENT && guard < 500) begin
      cfg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cfg_data  = frame[i];
      rdy = cfg_ready;
      @(posedge clk); #1;
      if (rdy && cfg_valid) begin
        i++;
        e_edge = cyc;
      end
      guard++;
    end
    n_cmp++;
    if (i != NENT) begin
      n_fail++;
      $display("FAIL stream_accepts: got %0d words, need %0d", i, NENT);
    end
    cfg_valid = hold;
    cfg_data  = 6'h3f;
  endtask

  task automatic wait_done();
    done_edge = -1;
    extra = 0;
    upd_at_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (cfg_ready && cfg_valid) extra++;
      @(posedge clk); #1;
      if (done) begin
        done_edge = cyc;
        upd_at_done = cfg_update;
        break;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_outcome(input string tag, input int bad);
    int exp_edge = (bad < 0) ? e_edge + NENT + 1 : e_edge + 1 + bad;
    if (bad < 0) exp_active = pack_frame();
    n_cmp++;
    if (done_edge != exp_edge) begin
      n_fail++;
      $display("FAIL %s done_edge: got E+%0d, need E+%0d", tag, done_edge - e_edge,
               exp_edge - e_edge);
    end
    n_cmp++;
    if (err !== (bad >= 0)) begin
      n_fail++;
      $display("FAIL %s err: got %b, need %b", tag, err, bad >= 0);
    end
    n_cmp++;
    if (bad >= 0 && err_idx !== 5'(bad)) begin
      n_fail++;
      $display("FAIL %s err_idx: got %0d, need %0d", tag, err_idx, bad);
    end
    n_cmp++;
    if (upd_at_done !== (bad < 0)) begin
      n_fail++;
      $display("FAIL %s cfg_update: got %b, need %b", tag, upd_at_done, bad < 0);
    end
    n_cmp++;
    if (cfg_active !== exp_active) begin
      n_fail++;
      $display("FAIL %s cfg_active: got %h, need %h", tag, cfg_active, exp_active);
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL %s extra_accepts: got %0d, need 0", tag, extra);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || cfg_update !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse_end: got done=%b upd=%b busy=%b, need 0/0/0", tag, done,
               cfg_update, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({cfg_ready, busy, done, err, cfg_update, err_idx} !== 10'b0 || cfg_active !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b err=%b upd=%b idx=%0d act=%h",
               cfg_ready, busy, done, err, cfg_update, err_idx, cfg_active);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_legal_frame();
    for (int k = 0; k < NENT; k++) frame[k] = '0;
    frame[0] = 6'b011_100;
    start_frame();
    n_cmp++;
    if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL legal_busy_ready: got busy=%b rdy=%b, need 1/1", busy, cfg_ready);
    end
    stream(1'b0, 1'b0);
    wait_done();
    check_outcome("legal", first_bad());
    n_cmp++;
    if (cfg_active[5:0] !== 6'b011100) begin
      n_fail++;
      $display("FAIL legal_top0: got %b, need 011100", cfg_active[5:0]);
    end
  endtask

  task automatic test_bad_source();
    for (int k = 0; k < NENT; k++) frame[k] = '0;
    frame[10] = 6'b100_010;
    start_frame();
    stream(1'b1, 1'b0);
    wait_done();
    check_outcome("bad_source", 10);
  endtask

  task automatic test_self_drive_and_select();
    for (int k = 0; k < NENT; k++) frame[k] = '0;
    frame[6] = 6'b001_011;
    start_frame();
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears_err: got %b, need 0", err);
    end
    stream(1'b0, 1'b0);
    wait_done();
    check_outcome("self_drive", 6);
    for (int k = 0; k < NENT; k++) frame[k] = '0;
    frame[0] = 6'b000_111;
    start_frame();
    stream(1'b0, 1'b1);
    wait_done();
    check_outcome("bad_select", 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 14; f++) begin
      bit allow_bad = (f % 2 == 1);
      for (int k = 0; k < NENT; k++) begin
        frame[k] = gen_word(allow_bad);
        while (!allow_bad && !legal_ref(k, frame[k])) frame[k] = gen_word(1'b0);
      end
      start_frame();
      stream(1'b1, 1'($urandom_range(0, 1)));
      wait_done();
      check_outcome("random", first_bad());
    end
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    for (int k = 0; k < NENT; k++) frame[k] = gen_word(1'b0);
    frame[0] = 6'b000_001;
    start_frame();
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = frame[i];
      @(posedge clk); #1;
    end
    cfg_valid = 1'b1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b rdy=%b, need 0/0", busy, cfg_ready);
    end
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done || cfg_update) seen = 1'b1;
    end
    n_cmp++;
    if (seen || err !== 1'b0 || cfg_active !== exp_active) begin
      n_fail++;
      $display("FAIL abort_quiet: got done_seen=%b err=%b act=%h, need 0/0/%h", seen, err,
               cfg_active, exp_active);
    end
    for (int k = 0; k < NENT; k++) begin
      frame[k] = gen_word(1'b0);
      while (!legal_ref(k, frame[k])) frame[k] = gen_word(1'b0);
    end
    start_frame();
    stream(1'b1, 1'b0);
    wait_done();
    check_outcome("after_abort", first_bad());
  endtask

  task automatic test_reset_mid_check();
    for (int k = 0; k < NENT; k++) begin
      frame[k] = gen_word(1'b0);
      while (!legal_ref(k, frame[k])) frame[k] = gen_word(1'b0);
    end
    start_frame();
    stream(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    cfg_start = 1'b1;
    #1;
    exp_active = '0;
    n_cmp++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0 || done !== 1'b0 || cfg_active !== exp_active) begin
      n_fail++;
      $display("FAIL reset_mid_check: got busy=%b rdy=%b done=%b act=%h, need all zero",
               busy, cfg_ready, done, cfg_active);
    end
    #1;
    cfg_start = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || cfg_active !== exp_active || err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b err=%b act=%h, need 0/0/0", busy, err,
               cfg_active);
    end
  endtask

  initial begin
    test_reset();
    test_legal_frame();
    test_bad_source();
    test_self_drive_and_select();
    test_random();
    test_abort();
    test_reset_mid_check();
    test_legal_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
